ahb_lite_master: RTL

Single-master AHB-Lite initiator that converts a simple valid/ready command stream into pipelined AHB transfers and returns one response per command. It sits directly upstream of `ahb_to_apb_bridge`: its HADDR/HTRANS/HWRITE/HWDATA/HSEL drive the bridge's AHB slave port, and the bridge's HRDATA/HRESP/HREADY_OUT feed back into it. The system has a single slave, so there is no decoder. The top level ties the bridge's HREADY_IN to its HREADY_OUT.

---
 rtl/ahb_pkg.sv | 23 ++
 rtl/ahb_lite_master.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_pkg
// Description : AHB-Lite transfer-type encoding and response codes shared by
//               the AHB-Lite master and the AHB-to-APB bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    // HTRANS encoding
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    // HRESP encoding
    localparam logic OKAY  = 1'b0;
    localparam logic ERROR = 1'b1;

endpackage : ahb_pkg
`default_nettype wire

// File: rtl/ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_master
// Description : Single-master AHB-Lite initiator. Turns a valid/ready command
//               stream into pipelined single NONSEQ transfers (address stage
//               + data stage) and returns one in-order response per command.
//               Handles wait states and the two-cycle ERROR response.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    // command stream
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // response stream
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    // AHB-Lite master port
    output logic                  HSEL,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HRESP,
    input  logic                  HREADY
);

    // address stage
    logic                  a_valid_q, a_valid_d;
    logic                  a_write_q, a_write_d;
    logic [ADDR_WIDTH-1:0] a_addr_q,  a_addr_d;
    logic [DATA_WIDTH-1:0] a_wdata_q, a_wdata_d;
    // data stage
    logic                  d_valid_q, d_valid_d;
    logic                  d_write_q, d_write_d;
    logic [DATA_WIDTH-1:0] d_wdata_q, d_wdata_d;
    // second cycle of an ERROR response: pending address phase masked to IDLE
    logic                  hold_idle_q, hold_idle_d;
    // registered response
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;

    logic                  w_issue;
    logic                  w_advance;

    assign w_issue   = a_valid_q & ~hold_idle_q;
    assign w_advance = HREADY & ~hold_idle_q;

    assign cmd_ready = w_advance;
    assign HSEL      = w_issue;
    assign HTRANS    = w_issue ? NONSEQ : IDLE;
    assign HADDR     = a_addr_q;
    assign HWRITE    = a_write_q;
    assign HWDATA    = d_wdata_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

    // Next-state: pipeline advance, error-retire and error-detect cases
    always_comb begin
        a_valid_d   = a_valid_q;
        a_write_d   = a_write_q;
        a_addr_d    = a_addr_q;
        a_wdata_d   = a_wdata_q;
        d_valid_d   = d_valid_q;
        d_write_d   = d_write_q;
        d_wdata_d   = d_wdata_q;
        hold_idle_d = hold_idle_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;

        if (w_advance) begin
            // normal edge: data stage <- address stage <- command
            d_valid_d = a_valid_q;
            d_write_d = a_write_q;
            d_wdata_d = a_wdata_q;
            a_valid_d = cmd_valid;
            if (cmd_valid) begin
                a_write_d = cmd_write;
                a_addr_d  = cmd_addr;
                a_wdata_d = cmd_wdata;
            end
            if (d_valid_q) begin
                rsp_valid_d = 1'b1;
                rsp_error_d = HRESP;
                rsp_rdata_d = d_write_q ? '0 : HRDATA;
            end
        end else if (HREADY) begin
            // end of the ERROR response: retire the data phase, keep the
            // masked address-stage transfer so it is re-issued next cycle
            hold_idle_d = 1'b0;
            d_valid_d   = 1'b0;
            if (d_valid_q) begin
                rsp_valid_d = 1'b1;
                rsp_error_d = HRESP;
                rsp_rdata_d = d_write_q ? '0 : HRDATA;
            end
        end else if ((HRESP == ERROR) && d_valid_q) begin
            // first ERROR cycle: mask the pending address phase next cycle
            hold_idle_d = 1'b1;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_valid_q   <= 1'b0;
            a_write_q   <= 1'b0;
            a_addr_q    <= '0;
            a_wdata_q   <= '0;
            d_valid_q   <= 1'b0;
            d_write_q   <= 1'b0;
            d_wdata_q   <= '0;
            hold_idle_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_write_q   <= a_write_d;
            a_addr_q    <= a_addr_d;
            a_wdata_q   <= a_wdata_d;
            d_valid_q   <= d_valid_d;
            d_write_q   <= d_write_d;
            d_wdata_q   <= d_wdata_d;
            hold_idle_q <= hold_idle_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

endmodule : ahb_lite_master
`default_nettype wire
